// File: rtl/issue_queue_wakeup.sv
// rtl/issue_queue_wakeup.sv - out-of-order issue queue with tag wake-up, oldest-first select and age flush
module issue_queue_wakeup #(
  parameter int DEPTH      = 16,
  parameter int PREG_W     = 6,
  parameter int ID_W       = 8,
  parameter int PAYLOAD_W  = 64,
  parameter int WAKE_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic [ID_W-1:0]              in_id,
  input  logic [PREG_W-1:0]            in_rs_tag,
  input  logic [PREG_W-1:0]            in_rt_tag,
  input  logic                         in_rs_rdy,
  input  logic                         in_rt_rdy,
  input  logic [WAKE_PORTS-1:0]        wake_valid,
  input  logic [WAKE_PORTS*PREG_W-1:0] wake_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [ID_W-1:0]              out_id,
  input  logic                         flush,
  input  logic [ID_W-1:0]              flush_id,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

  // Entry state: valid/ready bits are reset-relevant, the rest is plain storage
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     rs_rdy_q, rs_rdy_d;
  logic [DEPTH-1:0]     rt_rdy_q, rt_rdy_d;
  logic [IDX_W:0]       count_q, count_d;
  logic [ID_W-1:0]      id_q      [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [PREG_W-1:0]    rs_tag_q  [DEPTH];
  logic [PREG_W-1:0]    rt_tag_q  [DEPTH];

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [ID_W-1:0]  sel_id;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             enq;
  logic             iss;

  // Wrap-aware age: a is younger than b when (a - b) mod 2^ID_W is in [1, 2^(ID_W-1))
  function automatic logic younger(input logic [ID_W-1:0] a, input logic [ID_W-1:0] b);
    logic [ID_W-1:0] diff;
    diff = a - b;
    return (diff != '0) && !diff[ID_W-1];
  endfunction

  // True when any active wake port broadcasts this tag
  function automatic logic wake_hit(input logic [PREG_W-1:0]            tag,
                                    input logic [WAKE_PORTS-1:0]        wv,
                                    input logic [WAKE_PORTS*PREG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      if (wv[p] && (wt[p*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Pick the oldest entry with both sources ready
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_id    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && rs_rdy_q[i] && rt_rdy_q[i]) begin
        if (!sel_found || younger(sel_id, id_q[i])) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(i);
          sel_id    = id_q[i];
        end
      end
    end
  end

  // Lowest-index free slot for dispatch
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign in_ready    = (count_q < DEPTH_C) && !flush;
  assign out_valid   = sel_found && !flush;
  assign out_payload = payload_q[sel_idx];
  assign out_id      = id_q[sel_idx];
  assign count       = count_q;
  assign enq         = in_valid && in_ready && free_found;
  assign iss         = out_valid && out_ready;

  // Next entry state: wake-ups always apply; flush wins over issue/enqueue
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      rs_rdy_d[i] = rs_rdy_q[i] | wake_hit(rs_tag_q[i], wake_valid, wake_tag);
      rt_rdy_d[i] = rt_rdy_q[i] | wake_hit(rt_tag_q[i], wake_valid, wake_tag);
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && younger(id_q[i], flush_id)) valid_d[i] = 1'b0;
      end
    end else begin
      if (iss) valid_d[sel_idx] = 1'b0;
      if (enq) begin
        valid_d[free_idx]  = 1'b1;
        rs_rdy_d[free_idx] = in_rs_rdy | wake_hit(in_rs_tag, wake_valid, wake_tag);
        rt_rdy_d[free_idx] = in_rt_rdy | wake_hit(in_rt_tag, wake_valid, wake_tag);
      end
    end
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + (IDX_W + 1)'(valid_d[i]);
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= '0;
      rs_rdy_q <= '0;
      rt_rdy_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      rs_rdy_q <= rs_rdy_d;
      rt_rdy_q <= rt_rdy_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written only on accepted dispatch
  always_ff @(posedge clk) begin
    if (enq) begin
      id_q[free_idx]      <= in_id;
      payload_q[free_idx] <= in_payload;
      rs_tag_q[free_idx]  <= in_rs_tag;
      rt_tag_q[free_idx]  <= in_rt_tag;
    end
  end

endmodule

// File: doc/issue_queue_wakeup.md
Name: issue_queue_wakeup

Overview:
Parametrised out-of-order issue queue sitting between rename/dispatch and the execute stage of the MIPS core.
- Holds up to DEPTH renamed instructions, each with two physical source tags and per-source ready bits.
- Source ready bits are set by tag-match wake-up broadcasts on WAKE_PORTS ports.
- Issues the oldest fully-ready entry through a valid/ready handshake.
- Squashes all entries younger than a flush ID, using wrap-aware age comparison.

Parameters:
DEPTH, 16, number of queue entries; power of two, 4..64
PREG_W, 6, physical register tag width
ID_W, 8, instruction age ID width; DEPTH <= 2^(ID_W-1)
PAYLOAD_W, 64, opaque decoded-instruction payload width
WAKE_PORTS, 2, number of wake-up broadcast ports

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  dispatch offers an instruction
in_ready  out  1  queue accepts; = (count < DEPTH) & ~flush
in_payload  in  PAYLOAD_W  decoded fields, stored and returned unmodified
in_id  in  ID_W  age ID; increments by 1 (mod 2^ID_W) per accepted instruction
in_rs_tag, in_rt_tag  in  PREG_W each  source physical tags
in_rs_rdy, in_rt_rdy  in  1 each  source already available (or unused) at dispatch
wake_valid  in  WAKE_PORTS  per-port broadcast valid
wake_tag  in  WAKE_PORTS*PREG_W  port p occupies bits [p*PREG_W +: PREG_W]
out_valid  out  1  an entry is selected for issue
out_ready  in  1  execute stage accepts
out_payload  out  PAYLOAD_W  payload of the selected entry
out_id  out  ID_W  age ID of the selected entry
flush  in  1  squash request
flush_id  in  ID_W  ID of the mispredicted instruction; strictly younger entries are removed
count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
Reset
- rst_n low at a clk edge: all entry valid bits cleared, count = 0.
- Outputs after reset: out_valid = 0, in_ready = 1 (flush low).
- Out-of-reset storage contents are don't-care. Reset mid-operation discards all entries.

Age order
- younger(a,b) = ((a - b) mod 2^ID_W) lies in [1, 2^(ID_W-1)).
- Oldest-first selection uses this comparison. No counter-width assumption at wrap, e.g. ID_W = 8: 0x02 is younger than 0xFE.

Enqueue
- When in_valid & in_ready, the entry is written at the lowest-index free slot at the clk edge.
- Stored ready bits = in_*_rdy OR'd with any same-cycle wake match (wake bypass), so no wake-up is lost.
- An enqueued entry is issue-eligible no earlier than the following cycle.

Wake-up
- Each cycle, every valid entry with a source tag equal to any wake_tag[p] with wake_valid[p] sets that source ready bit at the edge.
- Wake in cycle N makes the entry eligible in cycle N+1.
- Duplicate tags across ports are harmless.

Select and issue (combinational)
- out_valid = ~flush & (any valid entry with both ready bits set).
- out_payload / out_id come from the oldest such entry.
- On out_valid & out_ready, that entry is invalidated at the edge.
- out_payload and out_id are held stable while out_valid & ~out_ready, unless an older entry becomes ready, in which case selection may change.

Count
- count updates at the edge: +1 on enqueue, -1 on issue, net 0 on both in the same cycle.
- At count == DEPTH, in_ready = 0 even if an issue occurs the same cycle; there is no same-cycle slot reuse.

Flush
- flush high at an edge: every entry with younger(entry_id, flush_id) is invalidated.
- Entries older than or equal to flush_id keep their state, including any wake-ups in that cycle.
- No enqueue or issue occurs in a flush cycle (in_ready = 0, out_valid = 0).
- A multi-cycle flush repeats this each cycle.

Empty
- out_valid = 0; out_payload / out_id are don't-care.

Test Plan:
- Reset then enqueue IDs 0x10 (rdy=1,1) and 0x11 (rdy=1,1), out_ready=1 -> issue 0x10 in the cycle after its enqueue, then 0x11; count returns 0.
- Enqueue 0x20 (rs_tag=5, not ready), then 0x21 (ready); pulse wake_valid[1] with tag 5 -> 0x21 issues first; 0x20 issues the cycle after the wake.
- Enqueue 0x30 with rs_tag=9 not ready while wake port 0 broadcasts tag 9 in the same cycle -> 0x30 is eligible the next cycle (bypass verified).
- Fill to DEPTH with IDs 0xF8..0x07 (wrapping), none ready -> in_ready=0 at count=DEPTH; wake all -> issue order 0xF8..0xFF, 0x00..0x07.
- Eight entries 0x40..0x47 pending; flush with flush_id=0x43 -> count=4 next cycle; only 0x40..0x43 later issue; in_ready=0 and out_valid=0 during the flush cycle.
- Queue holding 3 entries; assert rst_n=0 for one edge -> count=0, out_valid=0, no previously queued ID ever issues.
